// File: rtl/button_event_decoder.sv
// Turns a debounced button level into one-cycle press, release,
// long-press, auto-repeat and double-click event pulses.
module button_event_decoder #(
  parameter int unsigned LONG_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  parameter int unsigned DCLICK_CYCLES = 12_500_000,
  parameter int unsigned CNT_W         = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clean_i,
  output logic press_o,
  output logic release_o,
  output logic long_press_o,
  output logic repeat_pulse_o,
  output logic double_click_o,
  output logic held_o
);

  typedef enum logic [1:0] {
    IDLE,
    DOWN,
    HOLD,
    GAP
  } state_e;

  // Counter holds (elapsed cycles - 1) when a condition is evaluated
  localparam logic [CNT_W-1:0] LONG_M1 = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_M1  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DCL_M1  = CNT_W'(DCLICK_CYCLES - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             clean_q;
  logic             second_q;
  logic             press_q;
  logic             release_q;
  logic             long_q;
  logic             rep_q;
  logic             dclick_q;
  logic             held_q;
  logic             rise;
  logic             fall;

  assign rise  = clean_i & ~clean_q;
  assign fall  = ~clean_i & clean_q;
  assign cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      clean_q   <= 1'b0;
      second_q  <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      rep_q     <= 1'b0;
      dclick_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      clean_q   <= clean_i;
      cnt_q     <= cnt_d;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      rep_q     <= 1'b0;
      dclick_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            press_q  <= 1'b1;
            held_q   <= 1'b1;
            second_q <= 1'b0;
            cnt_q    <= '0;
            state_q  <= DOWN;
          end
        end
        DOWN: begin
          if (fall) begin
            release_q <= 1'b1;
            held_q    <= 1'b0;
            cnt_q     <= '0;
            state_q   <= second_q ? IDLE : GAP;
          end else if (cnt_q >= LONG_M1) begin
            long_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (fall) begin
            release_q <= 1'b1;
            held_q    <= 1'b0;
            cnt_q     <= '0;
            state_q   <= IDLE;
          end else if (cnt_q >= REP_M1) begin
            rep_q <= 1'b1;
            cnt_q <= '0;
          end
        end
        GAP: begin
          if (rise) begin
            press_q  <= 1'b1;
            dclick_q <= 1'b1;
            held_q   <= 1'b1;
            second_q <= 1'b1;
            cnt_q    <= '0;
            state_q  <= DOWN;
          end else if (cnt_q >= DCL_M1) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: begin
          held_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign press_o        = press_q;
  assign release_o      = release_q;
  assign long_press_o   = long_q;
  assign repeat_pulse_o = rep_q;
  assign double_click_o = dclick_q;
  assign held_o         = held_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with short timers
// (long=8, repeat=4, double-click window=6).
module tb_button_event_decoder;

  logic clk = 1'b0;
  logic rst_n;
  logic clean;
  logic press, rel, lng, rep, dcl, held;

  int errors = 0;
  int checks = 0;

  localparam logic [5:0] Z  = 6'b000000;
  localparam logic [5:0] P  = 6'b100000;
  localparam logic [5:0] R  = 6'b010000;
  localparam logic [5:0] L  = 6'b001000;
  localparam logic [5:0] RP = 6'b000100;
  localparam logic [5:0] D  = 6'b000010;
  localparam logic [5:0] H  = 6'b000001;

  button_event_decoder #(
    .LONG_CYCLES  (8),
    .REPEAT_CYCLES(4),
    .DCLICK_CYCLES(6),
    .CNT_W        (27)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clean_i       (clean),
    .press_o       (press),
    .release_o     (rel),
    .long_press_o  (lng),
    .repeat_pulse_o(rep),
    .double_click_o(dcl),
    .held_o        (held)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] outs();
    return {press, rel, lng, rep, dcl, held};
  endfunction

  task automatic chk(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = outs();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b (p r l rp dc h)",
             tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic c, input logic [5:0] exp,
                     input string tag);
    clean = c;
    @(posedge clk);
    #1;
    chk(tag, exp);
  endtask

  task automatic quiet(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(1'b0, Z, tag);
  endtask

  initial begin
    rst_n = 1'b0;
    clean = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", Z);
    rst_n = 1'b1;
    cyc(1'b0, Z, "idle");

    // short press: 3 cycles held
    cyc(1'b1, P | H, "t1_press");
    cyc(1'b1, H, "t1_held1");
    cyc(1'b1, H, "t1_held2");
    cyc(1'b0, R, "t1_release");
    quiet(6, "t1_gap");

    // long hold with repeats at k+12, k+16, k+20
    for (int i = 0; i <= 21; i++) begin
      logic [5:0] e;
      if (i == 0) e = P | H;
      else if (i == 21) e = R;
      else if (i == 8) e = L | H;
      else if (i > 8 && (i - 8) % 4 == 0) e = RP | H;
      else e = H;
      cyc(i <= 20, e, $sformatf("t2_hold_%0d", i));
    end
    quiet(2, "t2_after");

    // fall exactly at the long-press edge
    cyc(1'b1, P | H, "t3_press");
    for (int i = 1; i < 8; i++) cyc(1'b1, H, "t3_held");
    cyc(1'b0, R, "t3_edge_beats_timer");
    quiet(6, "t3_gap");

    // double click, then a plain third press
    cyc(1'b1, P | H, "t4_p1");
    cyc(1'b1, H, "t4_h1");
    cyc(1'b0, R, "t4_r1");
    cyc(1'b0, Z, "t4_g1");
    cyc(1'b0, Z, "t4_g2");
    cyc(1'b1, P | D | H, "t4_dclick");
    cyc(1'b1, H, "t4_h2");
    cyc(1'b0, R, "t4_r2");
    cyc(1'b0, Z, "t4_g3");
    cyc(1'b1, P | H, "t4_p3_plain");
    cyc(1'b1, H, "t4_h3");
    cyc(1'b0, R, "t4_r3");
    quiet(6, "t4_gap");

    // gap of 7 is too long; gap of exactly 6 still counts
    cyc(1'b1, P | H, "t5_p1");
    cyc(1'b0, R, "t5_r1");
    quiet(6, "t5_gap7");
    cyc(1'b1, P | H, "t5_plain");
    cyc(1'b0, R, "t5_r2");
    quiet(5, "t5_gap6");
    cyc(1'b1, P | D | H, "t5_dclick_edge");
    cyc(1'b0, R, "t5_r3");
    cyc(1'b0, Z, "t5_idle");

    // asynchronous reset in HOLD
    cyc(1'b1, P | H, "t6_press");
    for (int i = 1; i < 8; i++) cyc(1'b1, H, "t6_held");
    cyc(1'b1, L | H, "t6_long");
    cyc(1'b1, H, "t6_hold");
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_reset", Z);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, P | H, "t6_press_after_reset");
    cyc(1'b0, R, "t6_release");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
